// File: rtl/rom_stream_reader.sv
// ROM region reader: walks base_addr..base_addr+len-1 (wrapping) and streams each word on valid/ready.
// Optional running checksum of accepted words is built only when STREAM_READER_CHECKSUM_EN is defined.
module rom_stream_reader #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   len,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_dout,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] checksum
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [ADDR_W:0]   CNT_ONE  = 1;
  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

  state_t            state, state_next;
  logic [ADDR_W:0]   remaining, remaining_next;
  logic [ADDR_W-1:0] addr_next;
  logic [DATA_W-1:0] data_next;
  logic              valid_next;
  logic              last_next;
  logic              busy_next;
  logic              done_next;

  // Every output is a register; all of them clear asynchronously on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      remaining <= '0;
      rom_addr  <= '0;
      m_data    <= '0;
      m_valid   <= 1'b0;
      m_last    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_next;
      remaining <= remaining_next;
      rom_addr  <= addr_next;
      m_data    <= data_next;
      m_valid   <= valid_next;
      m_last    <= last_next;
      busy      <= busy_next;
      done      <= done_next;
    end
  end

  always_comb begin
    state_next     = state;
    remaining_next = remaining;
    addr_next      = rom_addr;
    data_next      = m_data;
    valid_next     = m_valid;
    last_next      = m_last;
    busy_next      = busy;
    done_next      = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          if (len != '0) begin
            remaining_next = len;
            addr_next      = base_addr;
            busy_next      = 1'b1;
            state_next     = FETCH;
          end else begin
            done_next = 1'b1;
          end
        end
      end

      FETCH: begin
        if (abort) begin
          valid_next = 1'b0;
          last_next  = 1'b0;
          busy_next  = 1'b0;
          state_next = IDLE;
        end else begin
          data_next  = rom_dout;
          valid_next = 1'b1;
          last_next  = (remaining == CNT_ONE);
          state_next = HOLD;
        end
      end

      HOLD: begin
        // abort outranks a handshake in the same cycle: the word is dropped uncounted
        if (abort) begin
          valid_next = 1'b0;
          last_next  = 1'b0;
          busy_next  = 1'b0;
          state_next = IDLE;
        end else if (m_valid && m_ready) begin
          valid_next     = 1'b0;
          remaining_next = remaining - CNT_ONE;
          if (m_last) begin
            last_next  = 1'b0;
            busy_next  = 1'b0;
            done_next  = 1'b1;
            state_next = IDLE;
          end else begin
            addr_next  = rom_addr + ADDR_ONE;
            state_next = FETCH;
          end
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

`ifdef STREAM_READER_CHECKSUM_EN
  function automatic logic [DATA_W-1:0] wrap_add(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
    return a + b;
  endfunction

  logic              sum_clr;
  logic              sum_add;
  logic [DATA_W-1:0] sum;

  assign sum_clr = (state == IDLE) && start;
  assign sum_add = (state == HOLD) && !abort && m_valid && m_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum <= '0;
    end else if (sum_clr) begin
      sum <= '0;
    end else if (sum_add) begin
      sum <= wrap_add(sum, m_data);
    end
  end

  assign checksum = sum;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_rom_stream_reader.sv
// Randomized bench for rom_stream_reader: a ROM array feeds the DUT and each transfer is
// checked against the word list base+i (mod depth), i < len, plus done/busy/checksum rules.
module tb_rom_stream_reader;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              abort;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   len;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_dout;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
  logic              m_last;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] checksum;

  logic [DATA_W-1:0] rom_mem [DEPTH];
  assign rom_dout = rom_mem[rom_addr];

  int checks   = 0;
  int failures = 0;
  int exp_sum  = 0;

  always #5 clk = ~clk;

  rom_stream_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .base_addr(base_addr), .len(len), .rom_addr(rom_addr), .rom_dout(rom_dout),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .busy(busy), .done(done), .checksum(checksum)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_ck();
`ifdef STREAM_READER_CHECKSUM_EN
    return exp_sum % 256;
`else
    return 0;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_rom_addr"}, rom_addr, 0);
    check_eq({tag, "_m_data"},   m_data,   0);
    check_eq({tag, "_m_valid"},  m_valid,  0);
    check_eq({tag, "_m_last"},   m_last,   0);
    check_eq({tag, "_busy"},     busy,     0);
    check_eq({tag, "_done"},     done,     0);
    check_eq({tag, "_checksum"}, checksum, 0);
  endtask

  // One transfer. abort_word<0 disables abort; stall_word gets exactly 3 stall cycles.
  task automatic run_xfer(input int base, input int n, input int max_stall,
                          input int abort_word, input bit abort_fetch,
                          input bit poke_start, input int stall_word);
    int          addr;
    int          stalls;
    bit          last;
    logic [7:0]  exp;
    base_addr = base[ADDR_W-1:0];
    len       = n[ADDR_W:0];
    start     = 1'b1;
    abort     = 1'($urandom_range(0, 1));
    step();
    start     = 1'b0;
    abort     = 1'b0;
    base_addr = 4'($urandom);
    len       = 5'($urandom);
    exp_sum   = 0;
    if (n == 0) begin
      check_eq("zero_done", done, 1);
      check_eq("zero_busy", busy, 0);
      check_eq("zero_valid", m_valid, 0);
      step();
      check_eq("zero_done_pulse", done, 0);
      check_eq("zero_valid2", m_valid, 0);
      check_eq("zero_ck", checksum, exp_ck());
      return;
    end
    check_eq("start_busy", busy, 1);
    check_eq("start_valid_early", m_valid, 0);
    check_eq("start_addr", rom_addr, base % DEPTH);
    for (int i = 0; i < n; i++) begin
      addr = (base + i) % DEPTH;
      exp  = rom_mem[addr];
      last = (i == n - 1);
      if (abort_fetch && i == abort_word) begin
        abort = 1'b1;
        step();
        abort = 1'b0;
        check_eq("abf_valid", m_valid, 0);
        check_eq("abf_busy", busy, 0);
        check_eq("abf_last", m_last, 0);
        check_eq("abf_done", done, 0);
        step();
        check_eq("abf_done2", done, 0);
        check_eq("abf_valid2", m_valid, 0);
        check_eq("abf_ck", checksum, exp_ck());
        return;
      end
      step();
      check_eq("word_valid", m_valid, 1);
      check_eq("word_data", m_data, exp);
      check_eq("word_addr", rom_addr, addr);
      check_eq("word_last", m_last, last);
      check_eq("word_busy", busy, 1);
      stalls = (i == stall_word) ? 3 : $urandom_range(0, max_stall);
      for (int s = 0; s < stalls; s++) begin
        m_ready = 1'b0;
        if (poke_start && s == 0) begin
          start     = 1'b1;
          base_addr = 4'($urandom);
          len       = 5'($urandom_range(1, 31));
        end
        step();
        start = 1'b0;
        check_eq("hold_valid", m_valid, 1);
        check_eq("hold_data", m_data, exp);
        check_eq("hold_addr", rom_addr, addr);
        check_eq("hold_last", m_last, last);
      end
      if (!abort_fetch && i == abort_word) begin
        abort   = 1'b1;
        m_ready = 1'($urandom_range(0, 1));
        step();
        abort   = 1'b0;
        m_ready = 1'b0;
        check_eq("abh_valid", m_valid, 0);
        check_eq("abh_busy", busy, 0);
        check_eq("abh_last", m_last, 0);
        check_eq("abh_done", done, 0);
        step();
        check_eq("abh_done2", done, 0);
        check_eq("abh_valid2", m_valid, 0);
        check_eq("abh_ck", checksum, exp_ck());
        return;
      end
      m_ready = 1'b1;
      step();
      m_ready = 1'b0;
      exp_sum = exp_sum + exp;
      check_eq("hs_valid_drop", m_valid, 0);
      if (last) begin
        check_eq("end_done", done, 1);
        check_eq("end_busy", busy, 0);
        check_eq("end_ck", checksum, exp_ck());
        step();
        check_eq("end_done_pulse", done, 0);
        check_eq("end_busy2", busy, 0);
        check_eq("end_valid", m_valid, 0);
      end
    end
  endtask

  initial begin
    rst_n     = 1'b1;
    start     = 1'b0;
    abort     = 1'b0;
    base_addr = '0;
    len       = '0;
    m_ready   = 1'b0;
    for (int i = 0; i < DEPTH; i++) rom_mem[i] = 8'(i * 3);
    #2 rst_n = 1'b0;
    #1 check_all_zero("reset");
    step();
    step();
    rst_n = 1'b1;
    step();

    // Basic walk, checksum of 0..21 step 3 is 84
    run_xfer(0, 8, 0, -1, 1'b0, 1'b0, -1);
`ifdef STREAM_READER_CHECKSUM_EN
    check_eq("t1_ck84", checksum, 84);
`endif
    // Backpressure on word 2
    run_xfer(0, 8, 0, -1, 1'b0, 1'b0, 2);
    // Wrap
    run_xfer(14, 4, 0, -1, 1'b0, 1'b0, -1);
    // Zero length, then start while busy
    run_xfer(3, 0, 0, -1, 1'b0, 1'b0, -1);
    run_xfer(2, 5, 2, -1, 1'b0, 1'b1, 1);
    // abort in IDLE is ignored
    abort = 1'b1;
    step();
    abort = 1'b0;
    check_eq("idle_abort_busy", busy, 0);
    check_eq("idle_abort_done", done, 0);
    check_eq("idle_abort_ck", checksum, exp_ck());
    // Abort in HOLD of word 3, then a fresh short transfer
    run_xfer(0, 8, 1, 3, 1'b0, 1'b0, -1);
    run_xfer(5, 2, 0, -1, 1'b0, 1'b0, -1);
    run_xfer(9, 6, 1, 2, 1'b1, 1'b0, -1);

    // Asynchronous reset mid-transfer
    base_addr = 4'd3;
    len       = 5'd5;
    start     = 1'b1;
    step();
    start = 1'b0;
    step();
    check_eq("pre_rst_valid", m_valid, 1);
    #3 rst_n = 1'b0;
    #1 check_all_zero("async_rst");
    exp_sum = 0;
    step();
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      m_ready = 1'b1;
      step();
      check_eq("post_rst_valid", m_valid, 0);
      check_eq("post_rst_busy", busy, 0);
      check_eq("post_rst_done", done, 0);
    end
    m_ready = 1'b0;

    // Randomized transfers over random ROM contents
    for (int i = 0; i < DEPTH; i++) rom_mem[i] = 8'($urandom);
    for (int t = 0; t < 30; t++) begin
      int n;
      int aw;
      n  = $urandom_range(0, 20);
      aw = ($urandom_range(0, 3) == 0 && n > 0) ? $urandom_range(0, n - 1) : -1;
      run_xfer($urandom_range(0, DEPTH - 1), n, 2, aw, 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), -1);
      if ($urandom_range(0, 1) == 1) step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
